// File: rtl/video_stream_pkg.sv
// Shared definitions for the video pixel requester: FIFO entry layout,
// requester state encoding and common raster sizes.
package video_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 24;

  // Sideband bits sit directly above the pixel data in a FIFO entry
  localparam int SOF_OFS       = 0;
  localparam int EOL_OFS       = 1;
  localparam int EOF_OFS       = 2;
  localparam int SIDEBAND_BITS = 3;

  localparam int RES_800X600_COLS   = 800;
  localparam int RES_800X600_ROWS   = 600;
  localparam int RES_1280X1024_COLS = 1280;
  localparam int RES_1280X1024_ROWS = 1024;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } req_state_t;

  typedef struct packed {
    logic valid;
    logic sof;
    logic eol;
    logic eof;
  } side_t;

  function automatic int side_pos(input int data_width, input int ofs);
    return data_width + ofs;
  endfunction

endpackage

// File: rtl/video_pixel_requester_if.sv
// AXI4-Stream video link carrying pixels from the requester to the HDMI path.
interface video_pixel_requester_if
  import video_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tuser,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/video_pixel_fifo.sv
// Synchronous FIFO with a registered head entry: a word pushed into an empty
// FIFO becomes visible on rdata one cycle later (no fall-through).
module video_pixel_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic [WIDTH-1:0] head_r, head_nxt_s;
  logic             do_push_s, do_pop_s;

  always_comb begin
    do_pop_s     = pop && (count_r != {CNT_W{1'b0}});
    do_push_s    = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);
    rd_ptr_nxt_s = do_pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
    // The slot being written becomes the head only when nothing older remains
    if (count_nxt_s == {CNT_W{1'b0}}) begin
      head_nxt_s = {WIDTH{1'b0}};
    end else if (do_push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = wdata;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      head_r   <= {WIDTH{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      head_r   <= head_nxt_s;
    end
  end

  always_comb begin
    rdata = head_r;
    count = count_r;
    full  = (count_r == CNT_W'(DEPTH));
    empty = (count_r == {CNT_W{1'b0}});
  end

endmodule

// File: rtl/video_pixel_requester.sv
// Raster-walking pixel fetcher: issues credit-throttled fetches, tags each with
// SOF/EOL/EOF, and replays the returned pixels as an AXI4-Stream video master.
module video_pixel_requester #(
  parameter int DATA_WIDTH     = 24,
  parameter int ROW_ADDR_WIDTH = 10,
  parameter int COL_ADDR_WIDTH = 11,
  parameter int MAX_COL        = 1280,
  parameter int MAX_ROW        = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  output logic                      next_pixel,
  output logic [ROW_ADDR_WIDTH-1:0] row_address,
  output logic [COL_ADDR_WIDTH-1:0] col_address,
  input  logic [DATA_WIDTH-1:0]     data_in,
  video_pixel_requester_if.master   m_axis,
  output logic                      frame_done
);

  import video_stream_pkg::*;

  localparam int ENTRY_W = DATA_WIDTH + SIDEBAND_BITS;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int CRED_W  = CNT_W + 1;
  localparam int SOF_POS = side_pos(DATA_WIDTH, SOF_OFS);
  localparam int EOL_POS = side_pos(DATA_WIDTH, EOL_OFS);
  localparam int EOF_POS = side_pos(DATA_WIDTH, EOF_OFS);

  req_state_t                state_r, state_nxt_s;
  logic [ROW_ADDR_WIDTH-1:0] row_r;
  logic [COL_ADDR_WIDTH-1:0] col_r;
  logic                      last_col_s, last_row_s, frame_end_s, frame_start_s;
  logic                      issue_s;
  side_t                     pipe_r [READ_LATENCY];
  side_t                     side_in_s;
  logic [CRED_W-1:0]         inflight_s, credit_s;
  logic [CNT_W-1:0]          fifo_count_s;
  logic                      fifo_full_s, fifo_empty_s, fifo_push_s, fifo_pop_s;
  logic [ENTRY_W-1:0]        push_entry_s, head_s;

  always_comb begin
    last_col_s    = (col_r == COL_ADDR_WIDTH'(MAX_COL - 1));
    last_row_s    = (row_r == ROW_ADDR_WIDTH'(MAX_ROW - 1));
    frame_end_s   = last_col_s && last_row_s;
    frame_start_s = (row_r == {ROW_ADDR_WIDTH{1'b0}}) && (col_r == {COL_ADDR_WIDTH{1'b0}});
  end

  // A fetch is allowed only if every outstanding pixel already has a FIFO slot
  always_comb begin
    inflight_s = {CRED_W{1'b0}};
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_s = inflight_s + CRED_W'(pipe_r[i].valid);
    end
    credit_s   = inflight_s + CRED_W'(fifo_count_s);
    issue_s    = (state_r == ST_RUN) && (credit_s < CRED_W'(FIFO_DEPTH)) && !fifo_full_s;
    next_pixel = issue_s;
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // enable only matters once the frame's final pixel is issued
        if (issue_s && frame_end_s && !enable) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_r <= {ROW_ADDR_WIDTH{1'b0}};
      col_r <= {COL_ADDR_WIDTH{1'b0}};
    end else if (issue_s) begin
      if (last_col_s) begin
        col_r <= {COL_ADDR_WIDTH{1'b0}};
        if (last_row_s) begin
          row_r <= {ROW_ADDR_WIDTH{1'b0}};
        end else begin
          row_r <= row_r + ROW_ADDR_WIDTH'(1);
        end
      end else begin
        col_r <= col_r + COL_ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    row_address     = row_r;
    col_address     = col_r;
    side_in_s.valid = issue_s;
    side_in_s.sof   = frame_start_s;
    side_in_s.eol   = last_col_s;
    side_in_s.eof   = frame_end_s;
    fifo_push_s     = pipe_r[READ_LATENCY-1].valid;
    push_entry_s                   = {ENTRY_W{1'b0}};
    push_entry_s[DATA_WIDTH-1:0]   = data_in;
    push_entry_s[SOF_POS]          = pipe_r[READ_LATENCY-1].sof;
    push_entry_s[EOL_POS]          = pipe_r[READ_LATENCY-1].eol;
    push_entry_s[EOF_POS]          = pipe_r[READ_LATENCY-1].eof;
  end

  // Sideband tags travel with each fetch until data_in returns
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_r[i] <= '{valid: 1'b0, sof: 1'b0, eol: 1'b0, eof: 1'b0};
      end
    end else begin
      pipe_r[0] <= side_in_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  video_pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .wdata (push_entry_s),
    .pop   (fifo_pop_s),
    .rdata (head_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  always_comb begin
    fifo_pop_s    = !fifo_empty_s && m_axis.tready;
    m_axis.tvalid = !fifo_empty_s;
    m_axis.tdata  = head_s[DATA_WIDTH-1:0];
    m_axis.tuser  = head_s[SOF_POS];
    m_axis.tlast  = head_s[EOL_POS];
    frame_done    = fifo_pop_s && head_s[EOF_POS];
  end

endmodule

// File: doc/video_pixel_requester.md
# video_pixel_requester

Initiator side of the row/column pixel-fetch interface used by the video pattern generator. It walks the raster, pulses `next_pixel` with `row_address`/`col_address`, and captures `data_in` after a fixed read latency. It buffers the captured pixels and emits them as an AXI4-Stream video master (SOF on `tuser`, EOL on `tlast`) toward the HDMI output path. `next_pixel` issue is throttled by a credit scheme, so downstream backpressure never drops a pixel.

## Interface
- `DATA_WIDTH`, 24, pixel width (RGB888)
- `ROW_ADDR_WIDTH`, 10, row address width
- `COL_ADDR_WIDTH`, 11, column address width
- `MAX_COL`, 1280, active pixels per line
- `MAX_ROW`, 1024, active lines per frame
- `READ_LATENCY`, 1, cycles from `next_pixel` to valid `data_in`; legal range 1..4
- `FIFO_DEPTH`, 8, output buffer entries; power of two, at least READ_LATENCY+2

Ports:
- `clk`  in  1  single clock (clk_100M domain)
- `rst`  in  1  synchronous, active-high reset
- `enable`  in  1  run request, sampled at frame boundaries only
- `next_pixel`  out  1  fetch strobe, one pixel per high cycle
- `row_address`  out  ROW_ADDR_WIDTH  row of the current fetch
- `col_address`  out  COL_ADDR_WIDTH  column of the current fetch
- `data_in`  in  DATA_WIDTH  pixel returned by the generator
- `m_axis_tdata`  out  DATA_WIDTH  pixel
- `m_axis_tvalid`  out  1  stream valid
- `m_axis_tready`  in  1  stream ready
- `m_axis_tuser`  out  1  start of frame, pixel (0,0)
- `m_axis_tlast`  out  1  end of line, col MAX_COL-1
- `frame_done`  out  1  one-cycle pulse when the last pixel of a frame is accepted

## Operation
- **State machine, IDLE / RUN**
  - IDLE → RUN when `enable`=1. Counters are already (0,0).
  - In RUN, the last pixel of a frame is (MAX_ROW-1, MAX_COL-1). When it issues:
    - `enable`=1: stay in RUN.
    - `enable`=0: go to IDLE.
  - In both cases the counters wrap to (0,0).
  - Deasserting `enable` mid-frame never truncates the frame.
- **Issue**
  - `next_pixel` = (state==RUN) && (inflight + fifo_count < FIFO_DEPTH).
  - `next_pixel` is combinational. `row_address`/`col_address` are registered counters and are valid whenever `next_pixel` is high.
- **Counter advance, on each issue**
  - col+1; at MAX_COL-1, col→0 and row+1.
  - At MAX_ROW-1 with col at MAX_COL-1, row→0.
- **Sideband pipeline**
  - READ_LATENCY stages carry {valid, sof, eol, eof} alongside each request.
  - When the final stage is valid, {data_in, sof, eol, eof} is written into the FIFO.
  - `inflight` is the number of valid pipeline stages.
- **FIFO**
  - Registered output, no fall-through.
  - Pop on `m_axis_tvalid && m_axis_tready`.
  - Simultaneous push and pop leaves the count unchanged.
  - Push when full is impossible by construction; the bench asserts this.
- **Output**
  - `m_axis_tvalid` = FIFO not empty.
  - `tdata`/`tuser`/`tlast` come from the FIFO head and are held stable while tvalid=1 && tready=0.
  - `frame_done` pulses on the cycle the eof entry is popped.

## Timing
- **Reset values**
  - State IDLE; counters (0,0); pipeline and FIFO cleared.
  - All outputs 0: `next_pixel`, addresses, tvalid, tuser, tlast, tdata, `frame_done`.
- `enable` sampled high at edge k (IDLE) → first `next_pixel` with (0,0) in the cycle after edge k.
- **Data capture**
  - Request in cycle t → `data_in` valid during cycle t+READ_LATENCY and written to the FIFO at the edge ending that cycle.
  - `m_axis_tvalid` for that pixel rises in cycle t+READ_LATENCY+1.
- **Throughput**
  - With tready held at 1, one pixel per cycle sustained, no bubbles, including across line and frame wrap.
- **Backpressure**
  - tready=0 fills the FIFO.
  - `next_pixel` stops once inflight + count reaches FIFO_DEPTH.
  - Issue resumes in the cycle after a pop frees a credit.
- `rst` mid-frame: outputs clear at the next edge. In-flight data is discarded. The next enabled frame starts at (0,0) with tuser=1.

## Structure
- **Shared package `video_stream_pkg`**
  - FIFO entry field offsets: SOF/EOL/EOF bits above DATA_WIDTH.
  - State encodings IDLE=0, RUN=1.
  - Default resolution constants for 800x600 and 1280x1024.
- **One sub-module `video_pixel_fifo`**
  - Synchronous FIFO, parameters WIDTH and DEPTH.
  - Outputs: count, full, empty.
  - The requester instantiates it with WIDTH = DATA_WIDTH+3.

## Test plan
- **Smoke frame**: MAX_COL=4, MAX_ROW=3, READ_LATENCY=1, tready=1, data_in = {row,col} echo model, enable pulsed. Required:
  - Exactly 12 beats, in order, data matches address.
  - tuser only on beat 0; tlast on beats 3, 7, 11.
  - `frame_done` on the beat-11 handshake, then IDLE.
- **Latency sweep**: READ_LATENCY = 1..4, tready=1. Required:
  - First tvalid exactly READ_LATENCY+1 cycles after the first `next_pixel`.
  - Sustained one beat per cycle.
- **Backpressure**: tready=0 for 20 cycles mid-line, FIFO_DEPTH=8. Required:
  - At most 8 outstanding.
  - `next_pixel` low while stalled, no push-when-full.
  - Stream resumes with no lost or duplicated pixel.
- **Random tready** (50%) over 3 frames with `enable` held high. Required: 36 beats in raster order with correct tuser/tlast, and 3 `frame_done` pulses.
- **Enable drop**: `enable` deasserted at pixel (1,2). Required: frame completes through (2,3), then `next_pixel` stays low.
- **Reset mid-frame** at pixel (1,1). Required:
  - All outputs 0 on the next cycle.
  - After re-enable, the first beat is (0,0) with tuser=1.
